fp_issue_queue: RTL and testbench
=================================

FP_ISSUE_QUEUE -- requirements
Module: fp_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning request FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning max cycles waiting for exe_ready before abort.
REQ-003 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-004 SHALL have port clock  in  1  clock; all state on rising edge.
REQ-005 SHALL have port in_valid  in  1  request valid.
REQ-006 SHALL have port in_ready  out  1  request accepted when in_valid&in_ready.
REQ-007 SHALL have ports in_data1, in_data2, in_data3  in  64 each  operands.
REQ-008 SHALL have ports in_fmt 2, in_rm 3, in_op 2  in  format, rounding mode, fcvt_op.
REQ-009 SHALL have port in_opcode  in  10  one-hot op: bit0 fmadd, 1 fadd, 2 fsub, 3 fmul, 4 fdiv, 5 fsqrt, 6 fcmp, 7 fcvt_f2f, 8 fcvt_i2f, 9 fcvt_f2i.
REQ-010 SHALL have port in_tag  in  4  request tag, returned with result.
REQ-011 SHALL have port exe_enable  out  1  single-cycle issue strobe to fp_unit.
REQ-012 SHALL have ports exe_data1/2/3 64, exe_fmt 2, exe_rm 3, exe_op 2, exe_opcode 10  out  operation fields to fp_unit.
REQ-013 SHALL have ports exe_ready in 1, exe_result in 64, exe_flags in 5  fp_unit completion.
REQ-014 SHALL have ports out_valid out 1, out_ready in 1  result handshake.
REQ-015 SHALL have ports out_result 64, out_flags 5, out_tag 4  out  completed result.
REQ-016 SHALL have ports busy out 1, timeout_err out 1  status.

Function
REQ-017 SHALL buffer requests in-order in a DEPTH-entry FIFO; in_ready = FIFO not full; no push when full even if pop same cycle.
REQ-018 SHALL implement FSM IDLE, ISSUE, WAIT, RESP; one operation in flight at a time.
REQ-019 IDLE: FIFO non-empty -> pop head into issue register; opcode one-hot -> ISSUE, else -> RESP with out_result 0, out_flags 5'b10000.
REQ-020 ISSUE: exe_enable=1 for exactly this cycle -> WAIT; exe_enable 0 in all other states.
REQ-021 exe_* fields SHALL come from issue register, stable from ISSUE until leaving WAIT.
REQ-022 WAIT: exe_ready sampled only here; on exe_ready capture exe_result, exe_flags, tag -> RESP.
REQ-023 WAIT cycle counter SHALL clear on entry; reaching TIMEOUT without exe_ready -> set timeout_err, result 0, flags 0 -> RESP.
REQ-024 RESP: out_valid=1, out_* stable until out_valid&out_ready, then -> IDLE same edge.
REQ-025 Latency: push at edge t -> exe_enable high cycle after t+1 edge when FSM idle and FIFO was empty; exe_ready at edge u -> out_valid high after edge u.
REQ-026 busy = (FSM != IDLE) | FIFO non-empty.
REQ-027 timeout_err SHALL be sticky; cleared only by reset.
REQ-028 out_tag SHALL equal in_tag of the corresponding request; results in acceptance order.

Reset
REQ-029 reset=0 SHALL empty FIFO, FSM -> IDLE, clear counter; outputs 0 except in_ready=1.
REQ-030 reset mid-operation SHALL abandon in-flight and queued requests; no out_valid for them.

Verification
REQ-031 fadd (opcode 10'h002) data1 3F800000, data2 40000000, tag 5; exe_ready 3 cycles after exe_enable with 40400000 -> one exe_enable pulse, out_result 40400000, out_tag 5.
REQ-032 push DEPTH+1 requests, exe_ready withheld -> in_ready 0 after DEPTH+1 accepted (1 in flight), no data loss; drain -> tags out in push order.
REQ-033 opcode 10'h006 (two bits) -> no exe_enable, out_result 0, out_flags 10000.
REQ-034 exe_ready never asserted -> after TIMEOUT cycles out_valid with result 0, timeout_err 1 until reset.
REQ-035 out_ready held 0 for 10 cycles -> out_* stable, next request not issued; release -> next exe_enable follows.
REQ-036 reset asserted in WAIT with 2 queued -> busy 0, out_valid 0, in_ready 1 after reset.

Source files
------------

// File: rtl/fp_issue_queue.sv
// ============================================================================
// Module      : fp_issue_queue
// Description : In-order request FIFO feeding a single-issue fp_unit, with a
//               completion timeout and a result handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        reset,
  input  logic        clock,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data1,
  input  logic [63:0] in_data2,
  input  logic [63:0] in_data3,
  input  logic [1:0]  in_fmt,
  input  logic [2:0]  in_rm,
  input  logic [1:0]  in_op,
  input  logic [9:0]  in_opcode,
  input  logic [3:0]  in_tag,
  output logic        exe_enable,
  output logic [63:0] exe_data1,
  output logic [63:0] exe_data2,
  output logic [63:0] exe_data3,
  output logic [1:0]  exe_fmt,
  output logic [2:0]  exe_rm,
  output logic [1:0]  exe_op,
  output logic [9:0]  exe_opcode,
  input  logic        exe_ready,
  input  logic [63:0] exe_result,
  input  logic [4:0]  exe_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [4:0]  out_flags,
  output logic [3:0]  out_tag,
  output logic        busy,
  output logic        timeout_err
);

  localparam int c_ADDR_W = $clog2(DEPTH);
  localparam int c_CNT_W  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;
  localparam logic [1:0] c_RESP  = 2'd3;

  typedef struct packed {
    logic [3:0]  tag;
    logic [9:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  rm;
    logic [1:0]  fmt;
    logic [63:0] data3;
    logic [63:0] data2;
    logic [63:0] data1;
  } entry_t;

  entry_t               r_fifo [DEPTH];
  logic [c_ADDR_W:0]    r_wr_ptr;
  logic [c_ADDR_W:0]    r_rd_ptr;
  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  entry_t               r_issue;
  logic [c_CNT_W-1:0]   r_wait_cnt;
  logic [63:0]          r_out_result;
  logic [4:0]           r_out_flags;
  logic [3:0]           r_out_tag;
  logic                 r_timeout_err;

  entry_t               w_head;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_onehot;
  logic                 w_expired;

  // Full when addresses match but the wrap bits differ.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]) &&
                     (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]);
  assign w_push    = in_valid && !w_full;
  assign w_pop     = (r_state == c_IDLE) && !w_empty;
  assign w_head    = r_fifo[r_rd_ptr[c_ADDR_W-1:0]];
  assign w_onehot  = (w_head.opcode != 10'd0) &&
                     ((w_head.opcode & (w_head.opcode - 10'd1)) == 10'd0);
  assign w_expired = (r_wait_cnt == c_CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo[r_wr_ptr[c_ADDR_W-1:0]] <= '{in_tag, in_opcode, in_op, in_rm, in_fmt,
                                          in_data3, in_data2, in_data1};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (!w_empty) w_next_state = w_onehot ? c_ISSUE : c_RESP;
      c_ISSUE: w_next_state = c_WAIT;
      c_WAIT:  if (exe_ready || w_expired) w_next_state = c_RESP;
      c_RESP:  if (out_ready) w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    exe_enable = (r_state == c_ISSUE);
    out_valid  = (r_state == c_RESP);
    busy       = (r_state != c_IDLE) || !w_empty;
    in_ready   = !w_full;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_issue       <= '0;
      r_wait_cnt    <= '0;
      r_out_result  <= '0;
      r_out_flags   <= '0;
      r_out_tag     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_issue  <= w_head;
        // Malformed opcodes bypass the unit and report only the invalid flag.
        if (!w_onehot) begin
          r_out_result <= '0;
          r_out_flags  <= 5'b10000;
          r_out_tag    <= w_head.tag;
        end
      end
      if (r_state == c_ISSUE) r_wait_cnt <= '0;
      if (r_state == c_WAIT) begin
        if (exe_ready) begin
          r_out_result <= exe_result;
          r_out_flags  <= exe_flags;
          r_out_tag    <= r_issue.tag;
        end else if (w_expired) begin
          r_out_result  <= '0;
          r_out_flags   <= '0;
          r_out_tag     <= r_issue.tag;
          r_timeout_err <= 1'b1;
        end else begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
        end
      end
    end
  end

  assign exe_data1   = r_issue.data1;
  assign exe_data2   = r_issue.data2;
  assign exe_data3   = r_issue.data3;
  assign exe_fmt     = r_issue.fmt;
  assign exe_rm      = r_issue.rm;
  assign exe_op      = r_issue.op;
  assign exe_opcode  = r_issue.opcode;
  assign out_result  = r_out_result;
  assign out_flags   = r_out_flags;
  assign out_tag     = r_out_tag;
  assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_fp_issue_queue.sv
// ============================================================================
// Module      : tb_fp_issue_queue
// Description : Directed self-checking bench for fp_issue_queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_issue_queue;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data1 = '0, in_data2 = '0, in_data3 = '0;
  logic [1:0]  in_fmt = '0;
  logic [2:0]  in_rm = '0;
  logic [1:0]  in_op = '0;
  logic [9:0]  in_opcode = '0;
  logic [3:0]  in_tag = '0;
  logic        exe_enable;
  logic [63:0] exe_data1, exe_data2, exe_data3;
  logic [1:0]  exe_fmt;
  logic [2:0]  exe_rm;
  logic [1:0]  exe_op;
  logic [9:0]  exe_opcode;
  logic        exe_ready = 1'b0;
  logic [63:0] exe_result = '0;
  logic [4:0]  exe_flags = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;
  logic [4:0]  out_flags;
  logic [3:0]  out_tag;
  logic        busy;
  logic        timeout_err;

  fp_issue_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .reset(reset), .clock(clock),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .in_fmt(in_fmt), .in_rm(in_rm), .in_op(in_op), .in_opcode(in_opcode), .in_tag(in_tag),
    .exe_enable(exe_enable),
    .exe_data1(exe_data1), .exe_data2(exe_data2), .exe_data3(exe_data3),
    .exe_fmt(exe_fmt), .exe_rm(exe_rm), .exe_op(exe_op), .exe_opcode(exe_opcode),
    .exe_ready(exe_ready), .exe_result(exe_result), .exe_flags(exe_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_tag(out_tag),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int en_pulses = 0;
  int accepted = 0;

  always @(posedge clock) begin
    if (exe_enable) en_pulses <= en_pulses + 1;
    if (in_valid && in_ready) accepted <= accepted + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] d1, input logic [63:0] d2,
                      input logic [9:0] opc, input logic [3:0] tag);
    int guard;
    guard     = 0;
    in_data1  = d1;
    in_data2  = d2;
    in_opcode = opc;
    in_tag    = tag;
    in_valid  = 1'b1;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!in_ready) check_eq("push_wait", 64'd0, 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_enable();
    int guard;
    guard = 0;
    while (!exe_enable && guard < 100) begin
      tick();
      guard++;
    end
    check_eq("exe_enable_seen", {63'd0, exe_enable}, 64'd1);
  endtask

  // Called while the queue sits in WAIT: return a result and drain it.
  task automatic complete_wait(input logic [63:0] res, input logic [4:0] flg, input logic [3:0] tag);
    exe_ready  = 1'b1;
    exe_result = res;
    exe_flags  = flg;
    tick();
    exe_ready  = 1'b0;
    check_eq("resp_valid", {63'd0, out_valid}, 64'd1);
    check_eq("resp_tag", {60'd0, out_tag}, {60'd0, tag});
    check_eq("resp_result", out_result, res);
    check_eq("resp_flags", {59'd0, out_flags}, {59'd0, flg});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int p0;
    int a0;
    int lat;

    // Reset state
    tick(); tick(); tick();
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_exe_enable", {63'd0, exe_enable}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_timeout_err", {63'd0, timeout_err}, 64'd0);
    check_eq("rst_out_result", out_result, 64'd0);
    reset = 1'b1;
    tick();

    // fadd with a 3-cycle unit delay
    p0 = en_pulses;
    push(64'h3F800000, 64'h40000000, 10'h002, 4'd5);
    check_eq("fadd_no_early_en", {63'd0, exe_enable}, 64'd0);
    check_eq("fadd_busy", {63'd0, busy}, 64'd1);
    tick();
    check_eq("fadd_en", {63'd0, exe_enable}, 64'd1);
    check_eq("fadd_data1", exe_data1, 64'h3F800000);
    check_eq("fadd_data2", exe_data2, 64'h40000000);
    check_eq("fadd_opcode", {54'd0, exe_opcode}, 64'h002);
    tick();
    check_eq("fadd_en_drop", {63'd0, exe_enable}, 64'd0);
    tick();
    tick();
    complete_wait(64'h40400000, 5'h01, 4'd5);
    check_eq("fadd_pulses", en_pulses - p0, 64'd1);
    check_eq("fadd_idle", {62'd0, out_valid, busy}, 64'd0);

    // Two-bit opcode is rejected without issuing
    p0 = en_pulses;
    push(64'h1, 64'h2, 10'h006, 4'd3);
    tick();
    check_eq("bad_valid", {63'd0, out_valid}, 64'd1);
    check_eq("bad_result", out_result, 64'd0);
    check_eq("bad_flags", {59'd0, out_flags}, 64'h10);
    check_eq("bad_tag", {60'd0, out_tag}, 64'd3);
    check_eq("bad_no_issue", en_pulses - p0, 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // DEPTH+1 requests fill the queue while the unit stalls
    a0 = accepted;
    for (int i = 1; i <= DEPTH + 1; i++) push(64'(i), 64'd0, 10'h008, 4'(i));
    check_eq("full_accepted", accepted - a0, 64'(DEPTH + 1));
    check_eq("full_in_ready", {63'd0, in_ready}, 64'd0);
    in_opcode = 10'h008;
    in_tag    = 4'd15;
    in_valid  = 1'b1;
    tick();
    tick();
    in_valid  = 1'b0;
    check_eq("full_no_push", accepted - a0, 64'(DEPTH + 1));
    complete_wait(64'hA1, 5'd0, 4'd1);
    for (int i = 2; i <= DEPTH + 1; i++) begin
      wait_enable();
      check_eq("drain_data1", exe_data1, 64'(i));
      tick();
      complete_wait(64'hA0 + 64'(i), 5'd0, 4'(i));
    end
    check_eq("drain_idle", {63'd0, busy}, 64'd0);

    // Back-pressure on the result port holds everything
    push(64'h7, 64'h0, 10'h010, 4'd7);
    push(64'h8, 64'h0, 10'h020, 4'd8);
    wait_enable();
    tick();
    exe_ready  = 1'b1;
    exe_result = 64'hDEAD_BEEF;
    exe_flags  = 5'h04;
    tick();
    exe_ready  = 1'b0;
    p0 = en_pulses;
    for (int i = 0; i < 10; i++) begin
      check_eq("hold_valid", {63'd0, out_valid}, 64'd1);
      check_eq("hold_result", out_result, 64'hDEAD_BEEF);
      check_eq("hold_tag", {60'd0, out_tag}, 64'd7);
      tick();
    end
    check_eq("hold_no_issue", en_pulses - p0, 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_enable();
    check_eq("hold_next_opcode", {54'd0, exe_opcode}, 64'h020);
    tick();
    complete_wait(64'h8888, 5'd0, 4'd8);

    // Unit never answers: timeout
    push(64'h9, 64'h0, 10'h002, 4'd9);
    wait_enable();
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check_eq("to_latency_ok", {63'd0, (lat >= TIMEOUT && lat <= TIMEOUT + 2)}, 64'd1);
    check_eq("to_valid", {63'd0, out_valid}, 64'd1);
    check_eq("to_result", out_result, 64'd0);
    check_eq("to_flags", {59'd0, out_flags}, 64'd0);
    check_eq("to_tag", {60'd0, out_tag}, 64'd9);
    check_eq("to_err", {63'd0, timeout_err}, 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    push(64'hA, 64'h0, 10'h002, 4'd10);
    wait_enable();
    tick();
    complete_wait(64'h1234, 5'd0, 4'd10);
    check_eq("to_err_sticky", {63'd0, timeout_err}, 64'd1);

    // Reset while waiting with two requests queued
    push(64'hB, 64'h0, 10'h002, 4'd11);
    push(64'hC, 64'h0, 10'h002, 4'd12);
    push(64'hD, 64'h0, 10'h002, 4'd13);
    check_eq("mid_busy", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_eq("mid_busy_clr", {63'd0, busy}, 64'd0);
    check_eq("mid_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("mid_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("mid_err_clr", {63'd0, timeout_err}, 64'd0);
    p0 = en_pulses;
    lat = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) lat++;
      tick();
    end
    check_eq("mid_no_resp", 64'(lat), 64'd0);
    check_eq("mid_no_issue", en_pulses - p0, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
